// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: ALU codes, opcodes,
// funct values, FSM state encoding and status-register bit positions.
package mips_pkg;

   localparam logic [4:0] ALU_AND = 5'b00000;
   localparam logic [4:0] ALU_OR  = 5'b00001;
   localparam logic [4:0] ALU_ADD = 5'b00010;
   localparam logic [4:0] ALU_SUB = 5'b01010;
   localparam logic [4:0] ALU_SLT = 5'b01011;
   localparam logic [4:0] ALU_NOR = 5'b11000;
   localparam logic [4:0] ALU_SLL = 5'b00100;
   localparam logic [4:0] ALU_SRL = 5'b00101;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_ADDI  = 6'h08;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_NOR = 6'h27;
   localparam logic [5:0] FN_SLT = 6'h2A;
   localparam logic [5:0] FN_SLL = 6'h00;
   localparam logic [5:0] FN_SRL = 6'h02;

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_EXEC_R    = 4'd2,
      S_R_WB      = 4'd3,
      S_MEM_ADDR  = 4'd4,
      S_MEM_READ  = 4'd5,
      S_MEM_WB    = 4'd6,
      S_MEM_WRITE = 4'd7,
      S_BRANCH    = 4'd8,
      S_JUMP      = 4'd9,
      S_EXEC_I    = 4'd10,
      S_I_WB      = 4'd11,
      S_ILLEGAL   = 4'd12
   } state_t;

   localparam int STATUS_V = 3;
   localparam int STATUS_N = 2;
   localparam int STATUS_Z = 1;
   localparam int STATUS_C = 0;

endpackage

// File: rtl/mips_alu_decoder.sv
// R-type funct to ALU control decode; valid flags functs the ALU supports.
module mips_alu_decoder
   import mips_pkg::*;
(
   input  logic [5:0] funct,
   output logic [4:0] alu_control,
   output logic       valid
);

   always_comb begin
      alu_control = ALU_ADD;
      valid       = 1'b1;
      case (funct)
         FN_ADD:  alu_control = ALU_ADD;
         FN_SUB:  alu_control = ALU_SUB;
         FN_AND:  alu_control = ALU_AND;
         FN_OR:   alu_control = ALU_OR;
         FN_NOR:  alu_control = ALU_NOR;
         FN_SLT:  alu_control = ALU_SLT;
         FN_SLL:  alu_control = ALU_SLL;
         FN_SRL:  alu_control = ALU_SRL;
         default: valid       = 1'b0;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS main control FSM driving the ALU, register file, memory
// port and status register. One state per clock, Moore outputs except BRANCH.
//
// state       | meaning
// ------------+-------------------------------------------------
// FETCH       | read instruction, load IR, PC <= PC + 4
// DECODE      | branch target into ALUOut, dispatch on opcode
// EXEC_R      | R-type ALU operation, latch status
// R_WB        | write ALUOut to rd
// MEM_ADDR    | base + imm address calculation
// MEM_READ    | read data memory at ALUOut
// MEM_WB      | write MDR to rt
// MEM_WRITE   | write regB to memory at ALUOut
// BRANCH      | compare regA/regB, load PC from ALUOut if equal
// JUMP        | load PC with jump target
// EXEC_I      | regA + imm, latch status
// I_WB        | write ALUOut to rt
// ILLEGAL     | one-cycle illegal pulse, no writes
module mips_multicycle_control
   import mips_pkg::*;
#(
   parameter int ALU_CTRL_WIDTH = 5,
   parameter int STATE_WIDTH    = 4
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [5:0]                opcode,
   input  logic [5:0]                funct,
   input  logic                      zero,
   output logic                      pcWrite,
   output logic                      iorD,
   output logic                      memRead,
   output logic                      memWrite,
   output logic                      irWrite,
   output logic                      memToReg,
   output logic                      regDst,
   output logic                      regWrite,
   output logic                      aluSrcA,
   output logic [1:0]                aluSrcB,
   output logic [1:0]                pcSource,
   output logic [ALU_CTRL_WIDTH-1:0] aluControl,
   output logic                      statusWrite,
   output logic                      illegal,
   output logic [STATE_WIDTH-1:0]    state
);

   state_t     state_q;
   state_t     state_d;

   logic [4:0] funct_alu;
   logic       funct_valid;

   logic       pc_write_c;
   logic       mem_write_c;
   logic       ir_write_c;
   logic       reg_write_c;
   logic       status_write_c;
   logic       illegal_c;
   logic [4:0] alu_control_c;

   mips_alu_decoder u_alu_decoder (
      .funct       (funct),
      .alu_control (funct_alu),
      .valid       (funct_valid)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d        = S_FETCH;
      pc_write_c     = 1'b0;
      iorD           = 1'b0;
      memRead        = 1'b0;
      mem_write_c    = 1'b0;
      ir_write_c     = 1'b0;
      memToReg       = 1'b0;
      regDst         = 1'b0;
      reg_write_c    = 1'b0;
      aluSrcA        = 1'b0;
      aluSrcB        = 2'd0;
      pcSource       = 2'd0;
      alu_control_c  = ALU_AND;
      status_write_c = 1'b0;
      illegal_c      = 1'b0;
      case (state_q)
         S_FETCH: begin
            memRead       = 1'b1;
            ir_write_c    = 1'b1;
            aluSrcB       = 2'd1;
            alu_control_c = ALU_ADD;
            pc_write_c    = 1'b1;
            state_d       = S_DECODE;
         end
         S_DECODE: begin
            aluSrcB       = 2'd3;
            alu_control_c = ALU_ADD;
            case (opcode)
               OP_RTYPE:     state_d = funct_valid ? S_EXEC_R : S_ILLEGAL;
               OP_LW, OP_SW: state_d = S_MEM_ADDR;
               OP_BEQ:       state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
               OP_ADDI:      state_d = S_EXEC_I;
               default:      state_d = S_ILLEGAL;
            endcase
         end
         S_EXEC_R: begin
            aluSrcA        = 1'b1;
            alu_control_c  = funct_alu;
            status_write_c = 1'b1;
            state_d        = S_R_WB;
         end
         S_R_WB: begin
            regDst      = 1'b1;
            reg_write_c = 1'b1;
         end
         S_MEM_ADDR: begin
            aluSrcA       = 1'b1;
            aluSrcB       = 2'd2;
            alu_control_c = ALU_ADD;
            // IR cannot change here, so anything but lw/sw is not reachable
            if (opcode == OP_LW)      state_d = S_MEM_READ;
            else if (opcode == OP_SW) state_d = S_MEM_WRITE;
         end
         S_MEM_READ: begin
            iorD    = 1'b1;
            memRead = 1'b1;
            state_d = S_MEM_WB;
         end
         S_MEM_WB: begin
            memToReg    = 1'b1;
            reg_write_c = 1'b1;
         end
         S_MEM_WRITE: begin
            iorD        = 1'b1;
            mem_write_c = 1'b1;
         end
         S_BRANCH: begin
            aluSrcA       = 1'b1;
            alu_control_c = ALU_SUB;
            pcSource      = 2'd1;
            pc_write_c    = zero;
         end
         S_JUMP: begin
            pcSource   = 2'd2;
            pc_write_c = 1'b1;
         end
         S_EXEC_I: begin
            aluSrcA        = 1'b1;
            aluSrcB        = 2'd2;
            alu_control_c  = ALU_ADD;
            status_write_c = 1'b1;
            state_d        = S_I_WB;
         end
         S_I_WB: begin
            reg_write_c = 1'b1;
         end
         S_ILLEGAL: begin
            illegal_c = 1'b1;
         end
         default: state_d = S_FETCH;
      endcase
   end

   // Write enables are gated by reset directly so an abort takes effect
   // without waiting for the state register to settle.
   assign pcWrite     = pc_write_c & ~reset;
   assign memWrite    = mem_write_c & ~reset;
   assign irWrite     = ir_write_c & ~reset;
   assign regWrite    = reg_write_c & ~reset;
   assign statusWrite = status_write_c & ~reset;
   assign illegal     = illegal_c & ~reset;
   assign aluControl  = ALU_CTRL_WIDTH'(alu_control_c);
   assign state       = STATE_WIDTH'(state_q);

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for mips_multicycle_control: per-cycle expected output rows
// are queued by the stimulus and popped by a negedge monitor.
module tb_mips_multicycle_control;
   import mips_pkg::*;

   logic       clock;
   logic       reset;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       pcWrite, iorD, memRead, memWrite, irWrite, memToReg, regDst, regWrite;
   logic       aluSrcA, statusWrite, illegal;
   logic [1:0] aluSrcB, pcSource;
   logic [4:0] aluControl;
   logic [3:0] state;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [23:0] v;
      string       tag;
   } exp_t;

   exp_t sb_q[$];

   mips_multicycle_control dut (
      .clock       (clock),
      .reset       (reset),
      .opcode      (opcode),
      .funct       (funct),
      .zero        (zero),
      .pcWrite     (pcWrite),
      .iorD        (iorD),
      .memRead     (memRead),
      .memWrite    (memWrite),
      .irWrite     (irWrite),
      .memToReg    (memToReg),
      .regDst      (regDst),
      .regWrite    (regWrite),
      .aluSrcA     (aluSrcA),
      .aluSrcB     (aluSrcB),
      .pcSource    (pcSource),
      .aluControl  (aluControl),
      .statusWrite (statusWrite),
      .illegal     (illegal),
      .state       (state)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   logic [23:0] act_vec;
   assign act_vec = {state, pcWrite, iorD, memRead, memWrite, irWrite, memToReg, regDst,
                     regWrite, aluSrcA, aluSrcB, pcSource, aluControl, statusWrite, illegal};

   function automatic logic [23:0] mk(input logic [3:0] st, input logic pcw, input logic iord,
                                      input logic mr, input logic mw, input logic irw,
                                      input logic m2r, input logic rd, input logic rw,
                                      input logic sa, input logic [1:0] sb, input logic [1:0] ps,
                                      input logic [4:0] alu, input logic sw, input logic ill);
      return {st, pcw, iord, mr, mw, irw, m2r, rd, rw, sa, sb, ps, alu, sw, ill};
   endfunction

   //                               st           pcw ior mr mw irw m2r rd rw sa  sb    ps    alu       sw ill
   function automatic logic [23:0] r_fetch();      return mk(S_FETCH,     1, 0, 1, 0, 1, 0, 0, 0, 0, 2'd1, 2'd0, 5'b00010, 0, 0); endfunction
   function automatic logic [23:0] r_reset();      return mk(S_FETCH,     0, 0, 1, 0, 0, 0, 0, 0, 0, 2'd1, 2'd0, 5'b00010, 0, 0); endfunction
   function automatic logic [23:0] r_decode();     return mk(S_DECODE,    0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd3, 2'd0, 5'b00010, 0, 0); endfunction
   function automatic logic [23:0] r_exec_r(input logic [4:0] a);
                                                   return mk(S_EXEC_R,    0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0, a,        1, 0); endfunction
   function automatic logic [23:0] r_r_wb();       return mk(S_R_WB,      0, 0, 0, 0, 0, 0, 1, 1, 0, 2'd0, 2'd0, 5'b00000, 0, 0); endfunction
   function automatic logic [23:0] r_mem_addr();   return mk(S_MEM_ADDR,  0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 2'd0, 5'b00010, 0, 0); endfunction
   function automatic logic [23:0] r_mem_read();   return mk(S_MEM_READ,  0, 1, 1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 5'b00000, 0, 0); endfunction
   function automatic logic [23:0] r_mem_wb();     return mk(S_MEM_WB,    0, 0, 0, 0, 0, 1, 0, 1, 0, 2'd0, 2'd0, 5'b00000, 0, 0); endfunction
   function automatic logic [23:0] r_mem_write();  return mk(S_MEM_WRITE, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 5'b00000, 0, 0); endfunction
   function automatic logic [23:0] r_branch(input logic z);
                                                   return mk(S_BRANCH,    z, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd1, 5'b01010, 0, 0); endfunction
   function automatic logic [23:0] r_jump();       return mk(S_JUMP,      1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 5'b00000, 0, 0); endfunction
   function automatic logic [23:0] r_exec_i();     return mk(S_EXEC_I,    0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 2'd0, 5'b00010, 1, 0); endfunction
   function automatic logic [23:0] r_i_wb();       return mk(S_I_WB,      0, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 5'b00000, 0, 0); endfunction
   function automatic logic [23:0] r_illegal();    return mk(S_ILLEGAL,   0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 5'b00000, 0, 1); endfunction

   task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input string tag, input logic [23:0] v);
      exp_t e;
      e.v   = v;
      e.tag = tag;
      sb_q.push_back(e);
   endtask

   // Drive one instruction starting in FETCH; ends 1 time unit after its last edge.
   task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z, input int n);
      opcode = op;
      funct  = fn;
      zero   = z;
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic do_rtype(input string tag, input logic [5:0] fn, input logic [4:0] alu);
      push({tag, " fetch"}, r_fetch());
      push({tag, " decode"}, r_decode());
      push({tag, " exec_r"}, r_exec_r(alu));
      push({tag, " r_wb"}, r_r_wb());
      run(6'h00, fn, 1'b0, 4);
   endtask

   always @(negedge clock) begin
      exp_t e;
      if (!reset && sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check(e.tag, act_vec, e.v);
      end
   end

   initial begin
      reset  = 1'b1;
      opcode = 6'h00;
      funct  = 6'h00;
      zero   = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check("reset_hold", act_vec, r_reset());
      reset = 1'b0;

      do_rtype("add", 6'h20, 5'b00010);

      push("lw fetch", r_fetch());
      push("lw decode", r_decode());
      push("lw mem_addr", r_mem_addr());
      push("lw mem_read", r_mem_read());
      push("lw mem_wb", r_mem_wb());
      run(6'h23, 6'h15, 1'b0, 5);

      push("sw fetch", r_fetch());
      push("sw decode", r_decode());
      push("sw mem_addr", r_mem_addr());
      push("sw mem_write", r_mem_write());
      run(6'h2B, 6'h00, 1'b0, 4);

      push("beq_z1 fetch", r_fetch());
      push("beq_z1 decode", r_decode());
      push("beq_z1 branch", r_branch(1'b1));
      run(6'h04, 6'h00, 1'b1, 3);

      push("beq_z0 fetch", r_fetch());
      push("beq_z0 decode", r_decode());
      push("beq_z0 branch", r_branch(1'b0));
      run(6'h04, 6'h00, 1'b0, 3);

      push("j fetch", r_fetch());
      push("j decode", r_decode());
      push("j jump", r_jump());
      run(6'h02, 6'h20, 1'b0, 3);

      push("addi fetch", r_fetch());
      push("addi decode", r_decode());
      push("addi exec_i", r_exec_i());
      push("addi i_wb", r_i_wb());
      run(6'h08, 6'h00, 1'b0, 4);

      do_rtype("sub", 6'h22, 5'b01010);
      do_rtype("and", 6'h24, 5'b00000);
      do_rtype("or",  6'h25, 5'b00001);
      do_rtype("nor", 6'h27, 5'b11000);
      do_rtype("slt", 6'h2A, 5'b01011);
      do_rtype("sll", 6'h00, 5'b00100);
      do_rtype("srl", 6'h02, 5'b00101);

      push("ill_op fetch", r_fetch());
      push("ill_op decode", r_decode());
      push("ill_op illegal", r_illegal());
      run(6'h3F, 6'h20, 1'b0, 3);

      push("ill_fn fetch", r_fetch());
      push("ill_fn decode", r_decode());
      push("ill_fn illegal", r_illegal());
      run(6'h00, 6'h18, 1'b0, 3);

      // Abort a store while it is writing memory
      push("abort fetch", r_fetch());
      push("abort decode", r_decode());
      push("abort mem_addr", r_mem_addr());
      run(6'h2B, 6'h00, 1'b0, 3);
      check("abort pre", act_vec, r_mem_write());
      #2;
      reset = 1'b1;
      #1;
      check("abort async", act_vec, r_reset());
      @(posedge clock);
      #1;
      check("abort held", act_vec, r_reset());
      reset = 1'b0;

      do_rtype("recover", 6'h20, 5'b00010);

      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", sb_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
